// File: rtl/softmax_max_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | softmax_pkg                                                                |
// | Shared constants, helpers and FSM encodings for the Softmax controllers.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package softmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Most-negative two's-complement value; caller truncates to its width.
    function automatic logic [63:0] min_val(input int width);
        return 64'(1) << (width - 1);
    endfunction

    function automatic int rounds(input int num);
        return $clog2(num);
    endfunction

endpackage
`default_nettype wire

// File: rtl/softmax_max_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | softmax_max_sched_if                                                       |
// | Vector-in / maximum-out handshake bundle for softmax_max_sched.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface softmax_max_sched_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int IN_DATA_NUM = 9
) ();
    logic                              in_valid;
    logic                              in_ready;
    logic [IN_DATA_NUM*DATA_WIDTH-1:0] in_data;
    logic                              abort;
    logic                              out_valid;
    logic                              out_ready;
    logic [DATA_WIDTH-1:0]             out_max;
    logic                              busy;

    modport slave (
        input  in_valid, in_data, abort, out_ready,
        output in_ready, out_valid, out_max, busy
    );

    modport master (
        output in_valid, in_data, abort, out_ready,
        input  in_ready, out_valid, out_max, busy
    );
endinterface
`default_nettype wire

// File: rtl/softmax_max_sched_eu_repack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eu_repack                                                                  |
// | Builds the next work vector from eu_row major lanes, single lane and MIN.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module eu_repack
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int IN_DATA_NUM = 9
) (
    input  wire logic [IN_DATA_NUM/2*DATA_WIDTH-1:0] eu_major_i,
    input  wire logic [DATA_WIDTH-1:0]               eu_single_i,
    output logic      [IN_DATA_NUM*DATA_WIDTH-1:0]   work_d_o
);
    localparam int                    HALF = IN_DATA_NUM / 2;
    localparam logic [63:0]           MIN_W = min_val(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MIN   = MIN_W[DATA_WIDTH-1:0];

    always_comb begin
        work_d_o = {IN_DATA_NUM{MIN}};
        work_d_o[0 +: HALF*DATA_WIDTH] = eu_major_i;
        if ((IN_DATA_NUM % 2) == 1) begin
            work_d_o[HALF*DATA_WIDTH +: DATA_WIDTH] = eu_single_i;
        end
    end
endmodule
`default_nettype wire

// File: rtl/softmax_max_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | softmax_max_sched                                                          |
// | Schedules a shared eu_row compare stage to reduce a vector to its maximum. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module softmax_max_sched
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int IN_DATA_NUM = 9,
    parameter int EU_LATENCY  = 1
) (
    input  wire logic                                clk,
    input  wire logic                                rst_n,
    softmax_max_sched_if.slave                       bus,
    output logic      [IN_DATA_NUM*DATA_WIDTH-1:0]   eu_data_o,
    input  wire logic [IN_DATA_NUM/2*DATA_WIDTH-1:0] eu_major,
    input  wire logic [DATA_WIDTH-1:0]               eu_single
);
    localparam int ROUNDS  = rounds(IN_DATA_NUM);
    localparam int RND_W   = $clog2(ROUNDS + 1);
    localparam int WCNT_W  = (EU_LATENCY > 0) ? $clog2(EU_LATENCY + 1) : 1;
    localparam int VEC_W   = IN_DATA_NUM * DATA_WIDTH;

    state_e              state_q, state_d;
    logic [VEC_W-1:0]    work_q, work_d;
    logic [RND_W-1:0]    rnd_q, rnd_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [VEC_W-1:0]    repack_w;

    eu_repack #(
        .DATA_WIDTH  (DATA_WIDTH),
        .IN_DATA_NUM (IN_DATA_NUM)
    ) u_repack (
        .eu_major_i  (eu_major),
        .eu_single_i (eu_single),
        .work_d_o    (repack_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            rnd_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rnd_q   <= rnd_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rnd_d   = rnd_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && !bus.abort) begin
                    work_d  = bus.in_data;
                    rnd_d   = RND_W'(ROUNDS);
                    wcnt_d  = WCNT_W'(EU_LATENCY);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else begin
                    // Capture edge: eu_row outputs have settled for the current work vector.
                    work_d = repack_w;
                    rnd_d  = rnd_q - RND_W'(1);
                    wcnt_d = WCNT_W'(EU_LATENCY);
                    if (rnd_q == RND_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.abort || bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign eu_data_o     = work_q;
    assign bus.out_max   = work_q[DATA_WIDTH-1:0];
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_softmax_max_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_softmax_max_sched                                                       |
// | Randomized self-checking bench with a one-cycle eu_row model.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_softmax_max_sched;
    localparam int DW = 8;
    localparam int N  = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N*DW-1:0]   eu_data;
    logic [N/2*DW-1:0] eu_major;
    logic [DW-1:0]     eu_single;

    int n_chk  = 0;
    int n_fail = 0;

    softmax_max_sched_if #(.DATA_WIDTH(DW), .IN_DATA_NUM(N)) u_if ();

    softmax_max_sched #(
        .DATA_WIDTH  (DW),
        .IN_DATA_NUM (N),
        .EU_LATENCY  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (u_if.slave),
        .eu_data_o (eu_data),
        .eu_major  (eu_major),
        .eu_single (eu_single)
    );

    always #5 clk = ~clk;

    // eu_row model: one register stage of pairwise signed maxima
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eu_major  <= '0;
            eu_single <= '0;
        end else begin
            for (int k = 0; k < N/2; k++) begin
                eu_major[k*DW +: DW] <= ($signed(eu_data[2*k*DW +: DW]) > $signed(eu_data[(2*k+1)*DW +: DW]))
                                        ? eu_data[2*k*DW +: DW] : eu_data[(2*k+1)*DW +: DW];
            end
            eu_single <= eu_data[(N-1)*DW +: DW];
        end
    end

    task automatic chk(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_max(input logic [N*DW-1:0] v);
        logic signed [DW-1:0] m;
        logic signed [DW-1:0] x;
        m = v[DW-1:0];
        for (int k = 1; k < N; k++) begin
            x = v[k*DW +: DW];
            if (x > m) m = x;
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts a vector, waits for the result, checks latency and value, then hands it off.
    task automatic run_vec(input string tag, input logic [N*DW-1:0] v, input int hold);
        int lat;
        logic [DW-1:0] m0;
        lat = 0;
        while (!u_if.in_ready && lat < 50) begin tick(); lat++; end
        chk({tag, "_ready"}, N*DW'(u_if.in_ready), N*DW'(1));
        u_if.in_valid = 1'b1;
        u_if.in_data  = v;
        tick();
        u_if.in_valid = 1'b0;
        lat = 0;
        while (!u_if.out_valid && lat < 100) begin tick(); lat++; end
        chk({tag, "_lat"}, N*DW'(lat), N*DW'(8));
        chk({tag, "_max"}, N*DW'(u_if.out_max), N*DW'(ref_max(v)));
        m0 = u_if.out_max;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold"}, {u_if.out_valid, u_if.in_ready, u_if.out_max}, {1'b1, 1'b0, m0});
        end
        u_if.out_ready = 1'b1;
        tick();
        u_if.out_ready = 1'b0;
        chk({tag, "_post"}, {u_if.out_valid, u_if.in_ready, u_if.busy}, {1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        logic [N*DW-1:0] v;
        logic [N*DW-1:0] vb;
        int  lat;
        logic bad;
        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.abort     = 1'b0;
        u_if.out_ready = 1'b0;
        #1;
        chk("rst_flags", {u_if.in_ready, u_if.out_valid, u_if.busy}, {1'b1, 1'b0, 1'b0});
        chk("rst_max", N*DW'(u_if.out_max), '0);
        chk("rst_eu", eu_data, '0);
        #12 rst_n = 1'b1;
        tick();

        run_vec("case1", 72'h0102_0408_0305_FD03_EE, 0);
        run_vec("case2", 72'h0802_0608_03DE_FD03_0A, 0);
        run_vec("single", {8'h7F, {8{8'h00}}}, 0);
        run_vec("allmin", {9{8'h80}}, 0);
        run_vec("stall", 72'h0102_0408_0305_FD03_EE, 5);

        // abort during round 2
        u_if.in_valid = 1'b1;
        u_if.in_data  = 72'h0102_0408_0305_FD03_EE;
        tick();
        u_if.in_valid = 1'b0;
        tick(); tick();
        u_if.abort = 1'b1;
        tick();
        u_if.abort = 1'b0;
        chk("abort_idle", {u_if.busy, u_if.in_ready, u_if.out_valid}, {1'b0, 1'b1, 1'b0});
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (u_if.out_valid) bad = 1'b1;
        end
        chk("abort_noout", N*DW'(bad), '0);
        run_vec("after_abort", 72'h0802_0608_03DE_FD03_0A, 0);

        // abort beats out_ready in DONE
        u_if.in_valid = 1'b1;
        u_if.in_data  = 72'h0802_0608_03DE_FD03_0A;
        tick();
        u_if.in_valid = 1'b0;
        lat = 0;
        while (!u_if.out_valid && lat < 100) begin tick(); lat++; end
        u_if.abort = 1'b1;
        u_if.out_ready = 1'b1;
        tick();
        u_if.abort = 1'b0;
        u_if.out_ready = 1'b0;
        chk("abort_done", {u_if.busy, u_if.out_valid}, {1'b0, 1'b0});

        // abort in IDLE blocks acceptance
        u_if.in_valid = 1'b1;
        u_if.abort    = 1'b1;
        tick();
        u_if.in_valid = 1'b0;
        u_if.abort    = 1'b0;
        chk("abort_idle_noacc", N*DW'(u_if.busy), '0);

        // async reset mid-RUN
        u_if.in_valid = 1'b1;
        u_if.in_data  = 72'h0102_0408_0305_FD03_EE;
        tick();
        u_if.in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("arst_flags", {u_if.in_ready, u_if.out_valid, u_if.busy}, {1'b1, 1'b0, 1'b0});
        chk("arst_data", {u_if.out_max, eu_data}, '0);
        #3 rst_n = 1'b1;
        tick();

        // in_valid held through busy: the changed in_data must be ignored until IDLE
        v  = 72'h0102_0408_0305_FD03_EE;
        vb = 72'h0802_0608_03DE_FD03_0A;
        u_if.in_valid = 1'b1;
        u_if.in_data  = v;
        tick();
        u_if.in_data = vb;
        bad = 1'b0;
        lat = 0;
        while (!u_if.out_valid && lat < 100) begin
            if (u_if.in_ready) bad = 1'b1;
            tick();
            lat++;
        end
        chk("held_ready_low", N*DW'(bad), '0);
        chk("held_first", N*DW'(u_if.out_max), N*DW'(ref_max(v)));
        u_if.out_ready = 1'b1;
        tick();
        u_if.out_ready = 1'b0;
        chk("held_bubble", {u_if.in_ready, u_if.busy}, {1'b1, 1'b0});
        tick();
        u_if.in_valid = 1'b0;
        chk("held_second_acc", N*DW'(u_if.busy), N*DW'(1));
        lat = 0;
        while (!u_if.out_valid && lat < 100) begin tick(); lat++; end
        chk("held_second", N*DW'(u_if.out_max), N*DW'(ref_max(vb)));
        u_if.out_ready = 1'b1;
        tick();
        u_if.out_ready = 1'b0;

        // randomized vectors with occasional extreme-value lanes
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 5))
                    0:       v[k*DW +: DW] = 8'h80;
                    1:       v[k*DW +: DW] = 8'h7F;
                    default: v[k*DW +: DW] = DW'($urandom);
                endcase
            end
            run_vec("rand", v, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
